alu_issue: RTL and testbench

Issue/writeback sequencer that drives the ALU from the decode side of the processor. It accepts one decoded instruction per valid/ready handshake, reads both operands from the register file, presents `op`/`x`/`y` to the ALU, and holds them for the required number of cycles. It then writes `w`, or the zero-extended `cmp`, back to the destination register. It sits between the decoder and the register-file write port and lets the core move from monocycle to multicycle execution.

---
 rtl/alu_issue_if.sv | 24 ++
 rtl/alu_issue.sv | 122 ++++++++++++
 tb/tb_alu_issue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Decode-side issue channel: one decoded instruction per valid/ready handshake.
interface alu_issue_if #(
    parameter int REG_FILE_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [5:0]                in_op;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic [REG_ADDR_WIDTH-1:0] in_rs1;
    logic [REG_ADDR_WIDTH-1:0] in_rs2;
    logic [REG_FILE_WIDTH-1:0] in_imm;
    logic                      in_use_imm;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_use_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_use_imm,
        output in_ready
    );
endinterface

// File: rtl/alu_issue.sv
// Multicycle issue/writeback sequencer: reads operands, holds ALU inputs for the
// op's latency, then writes the ALU result (or zero-extended compare) back.
module alu_issue #(
    parameter int REG_FILE_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MUL_LATENCY    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    alu_issue_if.slave                dec,
    output logic [REG_ADDR_WIDTH-1:0] rf_ra1,
    output logic [REG_ADDR_WIDTH-1:0] rf_ra2,
    input  logic [REG_FILE_WIDTH-1:0] rf_rd1,
    input  logic [REG_FILE_WIDTH-1:0] rf_rd2,
    output logic [5:0]                alu_op,
    output logic [REG_FILE_WIDTH-1:0] alu_x,
    output logic [REG_FILE_WIDTH-1:0] alu_y,
    input  logic [REG_FILE_WIDTH-1:0] alu_w,
    input  logic                      alu_cmp,
    output logic                      wb_en,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr,
    output logic [REG_FILE_WIDTH-1:0] wb_data,
    output logic                      busy,
    output logic                      err_op
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_MUL = 6'h02;
    localparam logic [5:0] OP_LT  = 6'h09;
    localparam logic [5:0] OP_GT  = 6'h0A;
    localparam logic [5:0] OP_EQ  = 6'h0B;

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    logic [1:0]                state_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic [5:0]                op_reg;
    logic [REG_ADDR_WIDTH-1:0] rd_reg;
    logic [REG_ADDR_WIDTH-1:0] rs1_reg;
    logic [REG_ADDR_WIDTH-1:0] rs2_reg;
    logic [REG_FILE_WIDTH-1:0] imm_reg;
    logic                      use_imm_reg;
    logic [REG_FILE_WIDTH-1:0] y_next;
    logic                      op_supported;
    logic                      op_is_cmp;

    assign dec.in_ready = !reset && (state_reg == ST_IDLE);
    assign busy         = (state_reg != ST_IDLE);
    assign rf_ra1       = rs1_reg;
    assign rf_ra2       = rs2_reg;

    assign op_supported = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_MUL) ||
                          (op_reg == OP_LT)  || (op_reg == OP_GT)  || (op_reg == OP_EQ);
    // alu_op is stable through EXEC, so it selects the capture format.
    assign op_is_cmp    = (alu_op == OP_LT) || (alu_op == OP_GT) || (alu_op == OP_EQ);

    genvar gi;
    generate
        for (gi = 0; gi < REG_FILE_WIDTH; gi++) begin : g_ysel
            assign y_next[gi] = use_imm_reg ? imm_reg[gi] : rf_rd2[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            alu_op    <= '0;
            alu_x     <= '0;
            alu_y     <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            err_op    <= 1'b0;
        end else begin
            wb_en  <= 1'b0;
            err_op <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (dec.in_valid) begin
                        op_reg      <= dec.in_op;
                        rd_reg      <= dec.in_rd;
                        rs1_reg     <= dec.in_rs1;
                        rs2_reg     <= dec.in_rs2;
                        imm_reg     <= dec.in_imm;
                        use_imm_reg <= dec.in_use_imm;
                        state_reg   <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_op  <= op_reg;
                    alu_x   <= rf_rd1;
                    alu_y   <= y_next;
                    cnt_reg <= (op_reg == OP_MUL) ? CNT_W'(MUL_LATENCY - 1) : '0;
                    if (op_supported) begin
                        state_reg <= ST_EXEC;
                    end else begin
                        err_op    <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (cnt_reg == '0) begin
                        wb_data   <= op_is_cmp ? {{(REG_FILE_WIDTH-1){1'b0}}, alu_cmp} : alu_w;
                        wb_addr   <= rd_reg;
                        // r0 is hardwired zero: pass through WB without writing.
                        wb_en     <= (rd_reg != '0);
                        state_reg <= ST_WB;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural register file and ALU.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rf_ra1, rf_ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic [5:0]  alu_op;
    logic [31:0] alu_x, alu_y, alu_w;
    logic        alu_cmp;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy, err_op;
    logic [31:0] rf [32];
    int          n_checks = 0;
    int          n_errors = 0;

    alu_issue_if #(.REG_FILE_WIDTH(32), .REG_ADDR_WIDTH(5)) dec_if ();

    alu_issue #(.REG_FILE_WIDTH(32), .REG_ADDR_WIDTH(5), .MUL_LATENCY(4)) dut (
        .clk(clk), .reset(reset), .dec(dec_if),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_w(alu_w), .alu_cmp(alu_cmp),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .err_op(err_op)
    );

    always #5 clk = ~clk;

    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];

    always_comb begin
        alu_w   = 32'h0;
        alu_cmp = 1'b0;
        case (alu_op)
            6'h00: alu_w = alu_x + alu_y;
            6'h01: alu_w = alu_x - alu_y;
            6'h02: alu_w = alu_x * alu_y;
            6'h09: alu_cmp = (alu_x < alu_y);
            6'h0A: alu_cmp = (alu_x > alu_y);
            6'h0B: alu_cmp = (alu_x == alu_y);
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (wb_en && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction; returns #1 after the accept edge (cycle N+1).
    task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic use_imm);
        dec_if.in_valid   = 1'b1;
        dec_if.in_op      = op;
        dec_if.in_rd      = rd;
        dec_if.in_rs1     = rs1;
        dec_if.in_rs2     = rs2;
        dec_if.in_imm     = imm;
        dec_if.in_use_imm = use_imm;
        check("ready_before_issue", {31'b0, dec_if.in_ready}, 32'd1);
        tick();
        dec_if.in_valid = 1'b0;
    endtask

    // Issues and watches cycles N+1..N+12 for writeback timing and content.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic use_imm, input int exp_wbs, input int exp_lat,
                          input logic [31:0] exp_data);
        int          wbs = 0;
        int          lat = 0;
        logic [31:0] data = 32'h0;
        logic [4:0]  addr = 5'h0;
        issue(op, rd, rs1, rs2, imm, use_imm);
        for (int c = 1; c <= 12; c++) begin
            if (wb_en) begin
                wbs++;
                lat  = c;
                data = wb_data;
                addr = wb_addr;
            end
            tick();
        end
        check({tag, "_wb_count"}, wbs, exp_wbs);
        if (exp_wbs != 0) begin
            check({tag, "_latency"}, lat, exp_lat);
            check({tag, "_wb_addr"}, {27'b0, addr}, {27'b0, rd});
            check({tag, "_wb_data"}, data, exp_data);
        end
        check({tag, "_ready_after"}, {31'b0, dec_if.in_ready}, 32'd1);
        $display("txn %s op=%h rd=%0d wbs=%0d lat=%0d data=%h", tag, op, rd, wbs, lat, data);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rf[5] = 32'h0001_0000;
        rf[6] = 32'h0001_0003;
        rf[7] = 32'd3;
        rf[8] = 32'd9;
        dec_if.in_valid   = 1'b0;
        dec_if.in_op      = 6'h0;
        dec_if.in_rd      = 5'h0;
        dec_if.in_rs1     = 5'h0;
        dec_if.in_rs2     = 5'h0;
        dec_if.in_imm     = 32'h0;
        dec_if.in_use_imm = 1'b0;

        tick();
        tick();
        check("rst_ready", {31'b0, dec_if.in_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_wb_en", {31'b0, wb_en}, 32'd0);
        check("rst_alu_x", alu_x, 32'd0);
        reset = 1'b0;
        #1;
        check("idle_ready", {31'b0, dec_if.in_ready}, 32'd1);
        $display("txn reset released");

        // ADD r3 <- r1 + r2, cycle-by-cycle.
        issue(6'h00, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
        check("add_n1_ready", {31'b0, dec_if.in_ready}, 32'd0);
        check("add_n1_busy", {31'b0, busy}, 32'd1);
        tick();
        check("add_n2_ready", {31'b0, dec_if.in_ready}, 32'd0);
        check("add_n2_wb_en", {31'b0, wb_en}, 32'd0);
        tick();
        check("add_n3_ready", {31'b0, dec_if.in_ready}, 32'd0);
        check("add_n3_wb_en", {31'b0, wb_en}, 32'd1);
        check("add_n3_wb_addr", {27'b0, wb_addr}, 32'd3);
        check("add_n3_wb_data", wb_data, 32'd12);
        tick();
        check("add_n4_wb_en", {31'b0, wb_en}, 32'd0);
        check("add_n4_ready", {31'b0, dec_if.in_ready}, 32'd1);
        $display("txn add r3 <- r1+r2 data=%h", 32'd12);

        run_op("sub_wrap", 6'h01, 5'd9, 5'd0, 5'd0, 32'd1, 1'b1, 1, 3, 32'hFFFF_FFFF);
        run_op("raw_add", 6'h00, 5'd12, 5'd3, 5'd0, 32'd1, 1'b1, 1, 3, 32'd13);

        // MUL r4 <- r5 * r6, operands held across four EXEC cycles.
        issue(6'h02, 5'd4, 5'd5, 5'd6, 32'h0, 1'b0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("mul_exec_x", alu_x, 32'h0001_0000);
            check("mul_exec_y", alu_y, 32'h0001_0003);
            check("mul_exec_wb_en", {31'b0, wb_en}, 32'd0);
        end
        tick();
        check("mul_n6_wb_en", {31'b0, wb_en}, 32'd1);
        check("mul_n6_wb_addr", {27'b0, wb_addr}, 32'd4);
        check("mul_n6_wb_data", wb_data, 32'h0003_0000);
        tick();
        check("mul_n7_ready", {31'b0, dec_if.in_ready}, 32'd1);
        $display("txn mul r4 <- r5*r6 data=%h", 32'h0003_0000);

        run_op("cmp_lt", 6'h09, 5'd10, 5'd7, 5'd8, 32'h0, 1'b0, 1, 3, 32'd1);
        run_op("cmp_gt", 6'h0A, 5'd11, 5'd7, 5'd8, 32'h0, 1'b0, 1, 3, 32'd0);
        run_op("cmp_eq", 6'h0B, 5'd13, 5'd7, 5'd8, 32'h0, 1'b0, 1, 3, 32'd0);
        run_op("rd_zero", 6'h09, 5'd0, 5'd7, 5'd8, 32'h0, 1'b0, 0, 0, 32'd0);

        // Unsupported opcode: err_op pulse in N+2, back to IDLE, no writeback.
        issue(6'h05, 5'd14, 5'd1, 5'd2, 32'h0, 1'b0);
        check("bad_n1_err", {31'b0, err_op}, 32'd0);
        tick();
        check("bad_n2_err", {31'b0, err_op}, 32'd1);
        check("bad_n2_ready", {31'b0, dec_if.in_ready}, 32'd1);
        check("bad_n2_wb_en", {31'b0, wb_en}, 32'd0);
        tick();
        check("bad_n3_err", {31'b0, err_op}, 32'd0);
        check("bad_n3_wb_en", {31'b0, wb_en}, 32'd0);
        $display("txn unsupported op 05");

        // Reset during MUL EXEC abandons the instruction.
        issue(6'h02, 5'd15, 5'd5, 5'd6, 32'h0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_ready", {31'b0, dec_if.in_ready}, 32'd0);
        check("mrst_alu_op", {26'b0, alu_op}, 32'd0);
        check("mrst_alu_x", alu_x, 32'd0);
        check("mrst_alu_y", alu_y, 32'd0);
        check("mrst_wb", {wb_en, err_op, 25'b0, wb_addr}, 32'd0);
        check("mrst_wb_data", wb_data, 32'd0);
        reset = 1'b0;
        begin
            int wbs = 0;
            for (int c = 0; c < 8; c++) begin
                if (wb_en) wbs++;
                tick();
            end
            check("mrst_no_wb", wbs, 0);
        end
        check("mrst_r15", rf[15], 32'd0);
        $display("txn reset during mul exec");

        run_op("post_rst_add", 6'h00, 5'd16, 5'd1, 5'd2, 32'h0, 1'b0, 1, 3, 32'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
